// File: rtl/weight_stream_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | weight_stream_loader_if                                                    |
// | HLS ap_fifo input stream plus ap_memory read port of the weight loader.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface weight_stream_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) ();

  logic [DATA_WIDTH-1:0] input_V_dout;
  logic                  input_V_empty_n;
  logic                  input_V_read;
  logic [ADDR_WIDTH-1:0] weight_V_address0;
  logic                  weight_V_ce0;
  logic [DATA_WIDTH-1:0] weight_V_q0;

  // The loader is the slave: it pops the stream and answers memory reads.
  modport slave (
    input  input_V_dout,
    input  input_V_empty_n,
    output input_V_read,
    input  weight_V_address0,
    input  weight_V_ce0,
    output weight_V_q0
  );

  modport master (
    output input_V_dout,
    output input_V_empty_n,
    input  input_V_read,
    output weight_V_address0,
    output weight_V_ce0,
    input  weight_V_q0
  );

endinterface
`default_nettype wire

// File: rtl/weight_stream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | weight_stream_loader                                                       |
// | Loads one kernel of coefficients from an ap_fifo stream into local RAM     |
// | and serves it through a 1-cycle-latency ap_memory read port.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module weight_stream_loader #(
  parameter int MEM_SIZE   = 288,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  wire logic              ap_clk,
  input  wire logic              ap_rst_n,
  input  wire logic              start,
  output logic                   ready,
  output logic [ADDR_WIDTH:0]    load_count,
  weight_stream_loader_if.slave  bus
);

  localparam int                  IDX_W      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] C_MEM_SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] C_LAST     = (ADDR_WIDTH+1)'(MEM_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [ADDR_WIDTH:0]   r_load_count;
  logic [DATA_WIDTH-1:0] r_q0;
  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

  logic                  w_wr_en;
  logic                  w_last;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_in_range;
  logic                  w_rd_en;

  // Popping is gated by state so the FIFO is never drained past one kernel.
  assign w_wr_en       = (r_state == S_LOAD) && bus.input_V_empty_n;
  assign w_last        = w_wr_en && (r_load_count == C_LAST);
  assign w_wr_idx      = r_load_count[IDX_W-1:0];
  assign w_rd_idx      = bus.weight_V_address0[IDX_W-1:0];
  assign w_rd_in_range = ({1'b0, bus.weight_V_address0} < C_MEM_SIZE);
  assign w_rd_en       = (r_state == S_READY) && bus.weight_V_ce0;

  assign bus.input_V_read = w_wr_en;
  assign bus.weight_V_q0  = r_q0;
  assign ready            = r_ready;
  assign load_count       = r_load_count;

  // Kernel storage has no reset so it maps onto block RAM.
  always_ff @(posedge ap_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= bus.input_V_dout;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_load_count <= '0;
      r_q0         <= '0;
    end else begin
      if (w_rd_en) begin
        r_q0 <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_ready      <= 1'b0;
            r_load_count <= '0;
          end
        end

        S_LOAD: begin
          // start is deliberately not looked at here, including on the final write.
          if (w_wr_en) begin
            r_load_count <= r_load_count + 1'b1;
            if (w_last) begin
              r_state <= S_READY;
              r_ready <= 1'b1;
            end
          end
        end

        S_READY: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_ready      <= 1'b0;
            r_load_count <= '0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b0;
          r_load_count <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_weight_stream_loader                                                    |
// | Directed bench with a read-data scoreboard and a modelled upstream FIFO.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_weight_stream_loader;

  localparam int MEM_SIZE   = 8;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;

  logic                  ap_clk   = 1'b0;
  logic                  ap_rst_n = 1'b0;
  logic                  start    = 1'b0;
  logic                  ready;
  logic [ADDR_WIDTH:0]   load_count;

  weight_stream_loader_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  weight_stream_loader #(
    .MEM_SIZE   (MEM_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .start      (start),
    .ready      (ready),
    .load_count (load_count),
    .bus        (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int n_pass  = 0;
  int n_total = 0;
  int pop_cnt = 0;
  int cyc     = 0;
  int viol    = 0;
  bit stall_en = 1'b0;
  logic [DATA_WIDTH-1:0] fifo_q [$];
  logic [DATA_WIDTH-1:0] exp_q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #3;
  endtask

  // Upstream FIFO model: pops on the edge where read was high, refreshes outputs after.
  initial begin
    bit pop_now;
    bus.input_V_dout    = '0;
    bus.input_V_empty_n = 1'b0;
    forever begin
      @(negedge ap_clk);
      pop_now = bus.input_V_read;
      if (bus.input_V_read && (ready || !bus.input_V_empty_n)) viol++;
      @(posedge ap_clk);
      #2;
      if (pop_now) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        else viol++;
        pop_cnt++;
      end
      cyc++;
      bus.input_V_empty_n = (fifo_q.size() > 0) && (!stall_en || (cyc % 3 == 0));
      bus.input_V_dout    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Read-port monitor: a ce0 seen at one edge is checked against q0 after that edge.
  initial begin
    bit pending = 1'b0;
    logic [DATA_WIDTH-1:0] e;
    forever begin
      @(negedge ap_clk);
      if (pending) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL q0_unexpected: got 0x%0h with no expected value queued", bus.weight_V_q0);
        end else begin
          e = exp_q.pop_front();
          chk("q0", 32'(bus.weight_V_q0), 32'(e));
        end
      end
      pending = bus.weight_V_ce0 && ap_rst_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic rd(input int a, input logic [DATA_WIDTH-1:0] e);
    bus.weight_V_address0 = ADDR_WIDTH'(a);
    bus.weight_V_ce0      = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.weight_V_ce0      = 1'b0;
  endtask

  task automatic push_words(input logic [DATA_WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DATA_WIDTH'(i));
  endtask

  task automatic do_start();
    pop_cnt = 0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Waits for ready; the pop count just before ready rose must be MEM_SIZE-1.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n    = 0;
    int prev = 0;
    bit done = 1'b0;
    while (!done && n < 200) begin
      prev = pop_cnt;
      tick();
      bus.weight_V_ce0 = 1'b0;
      n++;
      if (ready) done = 1'b1;
    end
    chk({name, "_ready"}, 32'(done), 32'd1);
    if (exp_cycles >= 0) chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({name, "_pops_before"}, 32'(prev), 32'(MEM_SIZE - 1));
    chk({name, "_pops"}, 32'(pop_cnt), 32'(MEM_SIZE));
    chk({name, "_load_count"}, 32'(load_count), 32'(MEM_SIZE));
  endtask

  initial begin
    bus.weight_V_address0 = '0;
    bus.weight_V_ce0      = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_q0", 32'(bus.weight_V_q0), 32'd0);
    chk("rst_read", 32'(bus.input_V_read), 32'd0);
    ap_rst_n = 1'b1;
    tick();

    // Back-to-back load with two surplus words, plus a read attempted during LOAD
    push_words(16'h0010, 8);
    fifo_q.push_back(16'h00AA);
    fifo_q.push_back(16'h00BB);
    tick();
    do_start();
    chk("b2b_start_ready", 32'(ready), 32'd0);
    chk("b2b_start_count", 32'(load_count), 32'd0);
    bus.weight_V_address0 = ADDR_WIDTH'(3);
    bus.weight_V_ce0      = 1'b1;
    exp_q.push_back(16'h0000);
    wait_ready("b2b", 8);
    for (int a = 0; a < 8; a++) rd(a, 16'h0010 + 16'(a));
    rd(9, 16'h0000);
    tick();
    chk("b2b_fifo_left", 32'(fifo_q.size()), 32'd2);
    fifo_q.delete();

    // Reload from READY while reading address 2
    push_words(16'h0100, 8);
    tick();
    pop_cnt = 0;
    start = 1'b1;
    bus.weight_V_address0 = ADDR_WIDTH'(2);
    bus.weight_V_ce0      = 1'b1;
    exp_q.push_back(16'h0012);
    tick();
    start = 1'b0;
    bus.weight_V_ce0 = 1'b0;
    chk("reload_ready_low", 32'(ready), 32'd0);
    chk("reload_count_zero", 32'(load_count), 32'd0);
    wait_ready("reload", 8);
    rd(2, 16'h0102);
    rd(7, 16'h0107);
    rd(0, 16'h0100);

    // Stalled stream: empty_n follows a 1,0,0 pattern
    stall_en = 1'b1;
    push_words(16'h0200, 8);
    fifo_q.push_back(16'h02CC);
    tick();
    do_start();
    wait_ready("stall", -1);
    for (int i = 0; i < 6; i++) tick();
    chk("stall_fifo_left", 32'(fifo_q.size()), 32'd1);
    for (int a = 0; a < 8; a++) rd(a, 16'h0200 + 16'(a));
    stall_en = 1'b0;
    fifo_q.delete();

    // Reset in the middle of a load
    push_words(16'h0300, 8);
    tick();
    do_start();
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_pops", 32'(pop_cnt), 32'd4);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_count", 32'(load_count), 32'd0);
    chk("midrst_read", 32'(bus.input_V_read), 32'd0);
    chk("midrst_q0", 32'(bus.weight_V_q0), 32'd0);
    tick();
    ap_rst_n = 1'b1;
    fifo_q.delete();
    push_words(16'h0400, 8);
    tick();
    do_start();
    wait_ready("after_rst", 8);
    rd(0, 16'h0400);
    rd(5, 16'h0405);
    rd(7, 16'h0407);

    // start pulses mid-load and on the final write are ignored
    push_words(16'h0500, 8);
    tick();
    do_start();
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 3 || n == 7) start = 1'b1;
      else start = 1'b0;
    end
    chk("ign_ready", 32'(ready), 32'd1);
    chk("ign_count", 32'(load_count), 32'd8);
    chk("ign_pops", 32'(pop_cnt), 32'd8);
    tick();
    tick();
    chk("ign_ready_hold", 32'(ready), 32'd1);
    chk("ign_count_hold", 32'(load_count), 32'd8);
    rd(4, 16'h0504);
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_protocol_violations", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
